// File: rtl/nvme_cq_handler_if.sv
// AXI bundle between the NVMe device, the CQ handler and the doorbell target.
// The slave modport is the handler's view: a CQ-window write slave plus a doorbell write master.
interface nvme_cq_handler_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ID_WIDTH-1:0]     cs_awid;
    logic [ADDR_WIDTH-1:0]   cs_awaddr;
    logic [7:0]              cs_awlen;
    logic [2:0]              cs_awsize;
    logic [1:0]              cs_awburst;
    logic                    cs_awvalid;
    logic                    cs_awready;
    logic [DATA_WIDTH-1:0]   cs_wdata;
    logic [DATA_WIDTH/8-1:0] cs_wstrb;
    logic                    cs_wlast;
    logic                    cs_wvalid;
    logic                    cs_wready;
    logic [ID_WIDTH-1:0]     cs_bid;
    logic [1:0]              cs_bresp;
    logic                    cs_bvalid;
    logic                    cs_bready;

    logic [ADDR_WIDTH-1:0]   db_awaddr;
    logic [7:0]              db_awlen;
    logic [2:0]              db_awsize;
    logic [1:0]              db_awburst;
    logic                    db_awvalid;
    logic                    db_awready;
    logic [DATA_WIDTH-1:0]   db_wdata;
    logic [DATA_WIDTH/8-1:0] db_wstrb;
    logic                    db_wlast;
    logic                    db_wvalid;
    logic                    db_wready;
    logic [1:0]              db_bresp;
    logic                    db_bvalid;
    logic                    db_bready;

    modport slave (
        input  cs_awid, cs_awaddr, cs_awlen, cs_awsize, cs_awburst, cs_awvalid,
        output cs_awready,
        input  cs_wdata, cs_wstrb, cs_wlast, cs_wvalid,
        output cs_wready,
        output cs_bid, cs_bresp, cs_bvalid,
        input  cs_bready,
        output db_awaddr, db_awlen, db_awsize, db_awburst, db_awvalid,
        input  db_awready,
        output db_wdata, db_wstrb, db_wlast, db_wvalid,
        input  db_wready,
        input  db_bresp, db_bvalid,
        output db_bready
    );

    modport master (
        output cs_awid, cs_awaddr, cs_awlen, cs_awsize, cs_awburst, cs_awvalid,
        input  cs_awready,
        output cs_wdata, cs_wstrb, cs_wlast, cs_wvalid,
        input  cs_wready,
        input  cs_bid, cs_bresp, cs_bvalid,
        output cs_bready,
        input  db_awaddr, db_awlen, db_awsize, db_awburst, db_awvalid,
        output db_awready,
        input  db_wdata, db_wstrb, db_wlast, db_wvalid,
        output db_wready,
        output db_bresp, db_bvalid,
        input  db_bready
    );
endinterface

// File: rtl/nvme_cq_handler.sv
// CQ entry consumer: one CQ write in flight, completion out after the last W beat, B after cpl handshake, then CQ head doorbell.
// Every stage holds until its handshake, so cs_awready stays low for the whole loop. CQ_DB_COALESCE_EN batches doorbells.
module nvme_cq_handler #(
    parameter int OUTSTANDING = 16,
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int CQ_BASE     = 132096,
    parameter int CQHDBL_ADDR = 1012,
    parameter int DB_COALESCE = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    nvme_cq_handler_if.slave               bus,
    output logic [$clog2(OUTSTANDING)-1:0] cq_sqhead,
    output logic                           cpl_valid,
    input  logic                           cpl_ready,
    output logic [15:0]                    cpl_cid,
    output logic [14:0]                    cpl_status,
    output logic                           cpl_err
);
    localparam int HW = $clog2(OUTSTANDING);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(CQ_BASE);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(CQ_BASE + 16 * OUTSTANDING);

    typedef enum logic [2:0] {IDLE, WDAT, CPL, BRESP, DB} state_t;

    state_t                state;
    logic                  awready, wready, bvalid;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  aw_pend, w_pend, db_bready_q;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic                  beat0;
    logic [HW-1:0]         lat_sqhd;
    logic [15:0]           lat_cid;
    logic                  lat_p;
    logic [14:0]           lat_status;
    logic                  ok_q, db_q;
    logic [HW-1:0]         cq_head;
    logic                  phase;

    logic [15:0]           e_cid;
    logic                  e_p;
    logic [14:0]           e_status;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_win, entry_ok;
    logic [HW-1:0]         head_next;

`ifdef CQ_DB_COALESCE_EN
    localparam int CW = $clog2(DB_COALESCE + 1);
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] cnt_next;
    assign cnt_next = db_cnt + 1'b1;
`endif

    // The last beat may also be beat 0, so decide on the live data in that case.
    always_comb begin
        e_cid    = lat_cid;
        e_p      = lat_p;
        e_status = lat_status;
        if (beat0) begin
            e_cid    = bus.cs_wdata[111:96];
            e_p      = bus.cs_wdata[112];
            e_status = bus.cs_wdata[127:113];
        end
    end

    assign offset    = aw_addr - BASE;
    assign in_win    = (aw_addr >= BASE) && (aw_addr < LIMIT);
    assign entry_ok  = (aw_len == 8'd0) && in_win && (offset[HW+3:4] == cq_head) && (e_p == phase);
    assign head_next = cq_head + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            awready     <= 1'b0;
            wready      <= 1'b0;
            bvalid      <= 1'b0;
            bid         <= '0;
            bresp       <= 2'b00;
            aw_pend     <= 1'b0;
            w_pend      <= 1'b0;
            db_bready_q <= 1'b0;
            aw_addr     <= '0;
            aw_len      <= '0;
            beat0       <= 1'b0;
            lat_sqhd    <= '0;
            lat_cid     <= '0;
            lat_p       <= 1'b0;
            lat_status  <= '0;
            ok_q        <= 1'b0;
            db_q        <= 1'b0;
            cq_head     <= '0;
            phase       <= 1'b1;
            cq_sqhead   <= '0;
            cpl_valid   <= 1'b0;
            cpl_cid     <= '0;
            cpl_status  <= '0;
            cpl_err     <= 1'b0;
`ifdef CQ_DB_COALESCE_EN
            db_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!awready) begin
                        awready <= 1'b1;
                    end else if (bus.cs_awvalid) begin
                        bid     <= bus.cs_awid;
                        aw_addr <= bus.cs_awaddr;
                        aw_len  <= bus.cs_awlen;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        beat0   <= 1'b1;
                        state   <= WDAT;
                    end
                end
                WDAT: begin
                    if (bus.cs_wvalid) begin
                        beat0 <= 1'b0;
                        if (beat0) begin
                            lat_sqhd   <= bus.cs_wdata[64+HW-1:64];
                            lat_cid    <= bus.cs_wdata[111:96];
                            lat_p      <= bus.cs_wdata[112];
                            lat_status <= bus.cs_wdata[127:113];
                        end
                        if (bus.cs_wlast) begin
                            wready <= 1'b0;
                            if (entry_ok) begin
                                cpl_valid  <= 1'b1;
                                cpl_cid    <= e_cid;
                                cpl_status <= e_status;
                                state      <= CPL;
                            end else begin
                                cpl_err <= 1'b1;
                                ok_q    <= 1'b0;
                                db_q    <= 1'b0;
                                bvalid  <= 1'b1;
                                bresp   <= 2'b10;
                                state   <= BRESP;
                            end
                        end
                    end
                end
                CPL: begin
                    if (cpl_ready) begin
                        cpl_valid <= 1'b0;
                        cq_sqhead <= lat_sqhd;
                        cq_head   <= head_next;
                        if (head_next == '0) phase <= ~phase;
                        ok_q      <= 1'b1;
`ifdef CQ_DB_COALESCE_EN
                        db_cnt    <= cnt_next;
                        db_q      <= (cnt_next == CW'(DB_COALESCE)) || (head_next == '0);
`else
                        db_q      <= 1'b1;
`endif
                        bvalid    <= 1'b1;
                        bresp     <= 2'b00;
                        state     <= BRESP;
                    end
                end
                BRESP: begin
                    if (bus.cs_bready) begin
                        bvalid <= 1'b0;
                        if (ok_q && db_q) begin
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                            state   <= DB;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DB: begin
                    if (aw_pend && bus.db_awready) aw_pend <= 1'b0;
                    if (w_pend && bus.db_wready) w_pend <= 1'b0;
                    if (!db_bready_q) begin
                        if ((!aw_pend || bus.db_awready) && (!w_pend || bus.db_wready))
                            db_bready_q <= 1'b1;
                    end else if (bus.db_bvalid) begin
                        db_bready_q <= 1'b0;
`ifdef CQ_DB_COALESCE_EN
                        db_cnt      <= '0;
`endif
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cs_awready = awready;
    assign bus.cs_wready  = wready;
    assign bus.cs_bvalid  = bvalid;
    assign bus.cs_bid     = bid;
    assign bus.cs_bresp   = bresp;

    // Doorbell payload always reflects the already-advanced head.
    assign bus.db_awaddr  = ADDR_WIDTH'(CQHDBL_ADDR);
    assign bus.db_awlen   = 8'd0;
    assign bus.db_awsize  = 3'd2;
    assign bus.db_awburst = 2'b01;
    assign bus.db_awvalid = aw_pend;
    assign bus.db_wdata   = DATA_WIDTH'({32'(cq_head), 32'h0});
    assign bus.db_wstrb   = SW'(16'h00F0);
    assign bus.db_wlast   = 1'b1;
    assign bus.db_wvalid  = w_pend;
    assign bus.db_bready  = db_bready_q;

    logic unused_ok;
    assign unused_ok = ^{bus.cs_awsize, bus.cs_awburst, bus.cs_wstrb, bus.db_bresp,
                         bus.cs_wdata[63:0], bus.cs_wdata[95:64+HW], offset[3:0],
                         offset[ADDR_WIDTH-1:HW+4]};
endmodule

// File: tb/tb_nvme_cq_handler.sv
// Randomized directed bench for nvme_cq_handler with a slot/phase/head reference model.
module tb_nvme_cq_handler;
    localparam int OUT     = 16;
    localparam int CQ_BASE = 132096;
    localparam int DBADDR  = 1012;
    localparam int DBC     = 4;

    logic        clk;
    logic        rstn;
    logic [3:0]  cq_sqhead;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [15:0] cpl_cid;
    logic [14:0] cpl_status;
    logic        cpl_err;

    nvme_cq_handler_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();

    nvme_cq_handler #(
        .OUTSTANDING(OUT), .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(128),
        .CQ_BASE(CQ_BASE), .CQHDBL_ADDR(DBADDR), .DB_COALESCE(DBC)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .cq_sqhead(cq_sqhead),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_cid(cpl_cid),
        .cpl_status(cpl_status), .cpl_err(cpl_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_head   = 0;
    bit m_phase  = 1'b1;
    int m_sqhead = 0;
    bit m_err    = 1'b0;
    int m_cnt    = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    task automatic model_reset();
        m_head = 0; m_phase = 1'b1; m_sqhead = 0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        @(negedge clk);
        bus.cs_awvalid = 1'b1; bus.cs_awid = id; bus.cs_awaddr = addr; bus.cs_awlen = len;
        n = 0;
        while (!bus.cs_awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) timeout("aw_accept");
        @(negedge clk);
        bus.cs_awvalid = 1'b0;
        check("awready_drop", bus.cs_awready, 1'b0);
    endtask

    task automatic send_w(input logic [127:0] d, input logic last);
        int n;
        bus.cs_wvalid = 1'b1; bus.cs_wdata = d; bus.cs_wlast = last;
        n = 0;
        while (!bus.cs_wready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) timeout("w_accept");
        @(negedge clk);
        bus.cs_wvalid = 1'b0; bus.cs_wlast = 1'b0;
    endtask

    function automatic logic [127:0] entry(input logic [15:0] sqhd, input logic [15:0] cid,
                                           input logic p, input logic [14:0] st);
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[79:64] = sqhd; d[111:96] = cid; d[112] = p; d[127:113] = st;
        return d;
    endfunction

    task automatic db_respond(input int head, input int aw_dly, input int w_dly);
        int aw_hs, w_hs, cyc, n;
        logic [127:0] exp_w;
        aw_hs = 0; w_hs = 0; cyc = 0;
        exp_w = '0; exp_w[63:32] = 32'(head);
        while ((aw_hs == 0 || w_hs == 0) && cyc < 100) begin
            check("db_bready_early", bus.db_bready, 1'b0);
            bus.db_awready = (cyc >= aw_dly);
            bus.db_wready  = (cyc >= w_dly);
            if (bus.db_awvalid && bus.db_awready) begin
                aw_hs++;
                check("db_awaddr", bus.db_awaddr, 32'(DBADDR));
                check("db_aw_len_size_burst", {bus.db_awlen, bus.db_awsize, bus.db_awburst}, {8'd0, 3'd2, 2'b01});
            end
            if (bus.db_wvalid && bus.db_wready) begin
                w_hs++;
                check("db_wdata", bus.db_wdata, exp_w);
                check("db_wstrb_wlast", {bus.db_wstrb, bus.db_wlast}, {16'h00F0, 1'b1});
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) timeout("db_handshakes");
        bus.db_awready = 1'b1; bus.db_wready = 1'b1; bus.db_bvalid = 1'b1;
        n = 0;
        while (n < 50) begin
            if (bus.db_awvalid) aw_hs++;
            if (bus.db_wvalid) w_hs++;
            if (bus.db_bready) break;
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("db_bready_wait");
        @(negedge clk);
        bus.db_bvalid = 1'b0; bus.db_awready = 1'b0; bus.db_wready = 1'b0;
        check("db_aw_count", aw_hs, 1);
        check("db_w_count", w_hs, 1);
        check("db_bready_drop", bus.db_bready, 1'b0);
    endtask

    task automatic post(input logic [31:0] addr, input logic [7:0] len, input logic p,
                        input logic [15:0] cid, input logic [15:0] sqhd, input logic [14:0] st,
                        input int cpl_dly, input int aw_dly, input int w_dly);
        logic [3:0] id;
        longint off;
        bit exp_ok, exp_db, saw_cpl, quiet;
        int n;
        id = 4'($urandom);
        off = longint'(addr) - longint'(CQ_BASE);
        exp_ok = (len == 8'd0) && (off >= 0) && (off < 16 * OUT) && ((off / 16) == m_head) && (p == m_phase);
        exp_db = 1'b0;
        send_aw(id, addr, len);
        for (int b = 0; b <= int'(len); b++)
            send_w(b == 0 ? entry(sqhd, cid, p, st) : {$urandom, $urandom, $urandom, $urandom}, b == int'(len));
        saw_cpl = 1'b0;
        if (exp_ok) begin
            n = 0;
            while (!cpl_valid && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) timeout("cpl_wait");
            check("bvalid_before_cpl", bus.cs_bvalid, 1'b0);
            check("cpl_cid", cpl_cid, cid);
            check("cpl_status", cpl_status, st);
            for (int k = 0; k < cpl_dly; k++) begin
                @(negedge clk);
                check("cpl_hold", {cpl_valid, cpl_cid, cpl_status}, {1'b1, cid, st});
            end
            cpl_ready = 1'b1;
            @(negedge clk);
            cpl_ready = 1'b0;
            check("cpl_drop", cpl_valid, 1'b0);
            m_sqhead = int'(sqhd) % OUT;
            m_head = (m_head + 1) % OUT;
            if (m_head == 0) m_phase = !m_phase;
`ifdef CQ_DB_COALESCE_EN
            m_cnt++;
            exp_db = (m_cnt == DBC) || (m_head == 0);
            if (exp_db) m_cnt = 0;
`else
            exp_db = 1'b1;
`endif
        end else begin
            m_err = 1'b1;
        end
        n = 0;
        while (!bus.cs_bvalid && n < 50) begin
            if (cpl_valid) saw_cpl = 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("b_wait");
        if (!exp_ok) check("no_cpl_on_bad", saw_cpl || cpl_valid, 1'b0);
        check("bid", bus.cs_bid, id);
        check("bresp", bus.cs_bresp, exp_ok ? 2'b00 : 2'b10);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check("bvalid_hold", bus.cs_bvalid, 1'b1);
        bus.cs_bready = 1'b1;
        @(negedge clk);
        bus.cs_bready = 1'b0;
        check("bvalid_drop", bus.cs_bvalid, 1'b0);
        check("cq_sqhead", cq_sqhead, m_sqhead);
        check("cpl_err", cpl_err, m_err);
        if (exp_db) begin
            db_respond(m_head, aw_dly, w_dly);
        end else begin
            quiet = 1'b1;
            repeat (6) begin
                if (bus.db_awvalid || bus.db_wvalid) quiet = 1'b0;
                @(negedge clk);
            end
            check("no_doorbell", quiet, 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int kind;
    logic [31:0] a;
    logic [7:0] l;
    logic pp;

    initial begin
        rstn = 1'b0; cpl_ready = 1'b0;
        bus.cs_awid = '0; bus.cs_awaddr = '0; bus.cs_awlen = '0; bus.cs_awsize = 3'd4;
        bus.cs_awburst = 2'b01; bus.cs_awvalid = 1'b0; bus.cs_wdata = '0; bus.cs_wstrb = '1;
        bus.cs_wlast = 1'b0; bus.cs_wvalid = 1'b0; bus.cs_bready = 1'b0;
        bus.db_awready = 1'b0; bus.db_wready = 1'b0; bus.db_bresp = 2'b00; bus.db_bvalid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cpl", {cpl_valid, cpl_cid, cpl_status, cpl_err, cq_sqhead}, '0);
        check("rst_cs_rdy_vld", {bus.cs_awready, bus.cs_wready, bus.cs_bvalid}, 3'b000);
        check("rst_db_vld_rdy", {bus.db_awvalid, bus.db_wvalid, bus.db_bready}, 3'b000);
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_awready", bus.cs_awready, 1'b1);

        // Slot 0, P=1, CID 5, SQHD 1
        post(32'(CQ_BASE), 8'd0, 1'b1, 16'd5, 16'd1, 15'd0, 0, 0, 0);
        check("t1_sqhead", cq_sqhead, 4'd1);

        // Fill the rest of the queue; phase flips after slot 15
        for (int i = 1; i < OUT; i++)
            post(32'(CQ_BASE + 16 * i), 8'd0, 1'b1, 16'($urandom), 16'($urandom), 15'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));

        // Stale phase at slot 0 after wrap
        post(32'(CQ_BASE), 8'd0, 1'b1, 16'h1234, 16'd7, 15'd0, 0, 0, 0);
        check("t2_err", cpl_err, 1'b1);

        // Head still 0: new phase accepted, with consumer and doorbell stalls
        post(32'(CQ_BASE), 8'd0, 1'b0, 16'hBEEF, 16'd9, 15'h2A5A, 10, 3, 0);

        // Wrong slot, burst, outside the window on both sides
        post(32'(CQ_BASE + 16 * 3), 8'd0, m_phase, 16'd3, 16'd3, 15'd0, 0, 0, 0);
        post(32'(CQ_BASE + 16 * m_head), 8'd1, m_phase, 16'd4, 16'd4, 15'd0, 0, 0, 0);
        post(32'(CQ_BASE + 16 * OUT), 8'd0, m_phase, 16'd6, 16'd6, 15'd0, 0, 0, 0);
        post(32'(CQ_BASE - 16), 8'd0, m_phase, 16'd7, 16'd7, 15'd0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            a = 32'(CQ_BASE + 16 * m_head);
            l = 8'd0;
            pp = m_phase;
            case (kind)
                7: a = 32'(CQ_BASE + 16 * ((m_head + $urandom_range(1, OUT - 1)) % OUT));
                8: pp = !m_phase;
                9: l = 8'($urandom_range(1, 3));
                default: ;
            endcase
            post(a, l, pp, 16'($urandom), 16'($urandom), 15'($urandom),
                 $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Reset collides with cpl_ready: completion is lost and state returns to reset values
        send_aw(4'd1, 32'(CQ_BASE + 16 * m_head), 8'd0);
        send_w(entry(16'd11, 16'h0ABC, m_phase, 15'd1), 1'b1);
        check("rc_cpl_valid", cpl_valid, 1'b1);
        cpl_ready = 1'b1;
        rstn = 1'b0;
        #1;
        check("rc_cpl_drop", cpl_valid, 1'b0);
        @(negedge clk);
        cpl_ready = 1'b0;
        check("rc_state", {cq_sqhead, cpl_err, bus.cs_bvalid, bus.db_awvalid, bus.db_wvalid}, '0);
        rstn = 1'b1;
        model_reset();
        post(32'(CQ_BASE), 8'd0, 1'b1, 16'h0F0F, 16'd2, 15'd3, 1, 1, 2);
        check("rc_after_sqhead", cq_sqhead, 4'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
